// File: rtl/div_fl_seq_pkg.sv
// div_fl_seq_pkg: float format constants, FSM states and field helpers shared by the float datapath
package div_fl_seq_pkg;
   localparam int NBMANT = 22;
   localparam int NBEXPO = 6;
   localparam int NBW    = NBMANT + NBEXPO + 1;
   localparam int NBE    = NBEXPO + 2;
   localparam logic signed [NBE-1:0] EXP_MAX = NBE'(2 ** (NBEXPO - 1) - 1);
   localparam logic signed [NBE-1:0] EXP_MIN = NBE'(-(2 ** (NBEXPO - 1)));
   localparam logic [NBEXPO-1:0] EXPO_TOP  = {1'b0, {(NBEXPO-1){1'b1}}};
   localparam logic [NBEXPO-1:0] EXPO_BOT  = {1'b1, {(NBEXPO-1){1'b0}}};
   localparam logic [NBMANT-1:0] MANT_ONES = '1;
   localparam logic [NBW-1:0] ZERO   = {1'b0, EXPO_BOT, {NBMANT{1'b0}}};
   localparam logic [NBW-1:0] MAXMAG = {1'b0, EXPO_TOP, MANT_ONES};

   typedef enum logic [1:0] {IDLE, CALC, NORM, FIN} state_e;

   function automatic logic f_sign(input logic [NBW-1:0] x);
      return x[NBW-1];
   endfunction

   function automatic logic signed [NBE-1:0] f_expo(input logic [NBW-1:0] x);
      return NBE'($signed(x[NBW-2:NBMANT]));
   endfunction

   function automatic logic [NBMANT-1:0] f_mant(input logic [NBW-1:0] x);
      return x[NBMANT-1:0];
   endfunction

   function automatic logic [NBW-1:0] f_pack(input logic s, input logic [NBEXPO-1:0] e,
                                             input logic [NBMANT-1:0] m);
      return {s, e, m};
   endfunction
endpackage

// File: rtl/div_fl_seq_if.sv
// div_fl_seq_if: request/result bundle between the float control and the divider
interface div_fl_seq_if;
   import div_fl_seq_pkg::*;
   logic           start;
   logic [NBW-1:0] a;
   logic [NBW-1:0] b;
   logic           busy;
   logic           done;
   logic [NBW-1:0] out;
   logic           div0;
   modport master (output start, a, b, input busy, done, out, div0);
   modport slave  (input start, a, b, output busy, done, out, div0);
endinterface

// File: rtl/div_fl_seq_mant_core.sv
// div_fl_seq_mant_core: iterative unsigned restoring mantissa divider, one quotient bit per cycle
module div_fl_seq_mant_core #(
   parameter int NB = 22
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [NB-1:0] ma_i,
   input  logic [NB-1:0] mb_i,
   output logic [NB:0] q_o,
   output logic        last_o
);
   localparam int CW = $clog2(NB + 2);
   logic [NB:0]   rem_q, rem_d, rem_n, q_q, q_d;
   logic [NB-1:0] mb_q;
   logic [CW-1:0] cnt_q;
   logic [NB+1:0] diff;
   logic          borrow;

   // Trial subtraction: keep the remainder on borrow, otherwise take the difference, then shift
   always_comb begin
      diff   = {1'b0, rem_q} - {2'b00, mb_q};
      borrow = diff[NB+1];
      rem_n  = borrow ? rem_q : diff[NB:0];
      rem_d  = {rem_n[NB-1:0], 1'b0};
      q_d    = {q_q[NB-1:0], ~borrow};
   end

   // Load operands and run NB+1 iterations, counting down to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         mb_q  <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else if (load_i) begin
         rem_q <= {1'b0, ma_i};
         mb_q  <= mb_i;
         q_q   <= '0;
         cnt_q <= CW'(NB + 1);
      end else if (cnt_q != '0) begin
         rem_q <= rem_d;
         q_q   <= q_d;
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign q_o    = q_q;
   assign last_o = cnt_q == CW'(1);
endmodule

// File: rtl/div_fl_seq.sv
// div_fl_seq: constant-latency floating-point divider (sign/exponent path, special cases, saturation)
module div_fl_seq
   import div_fl_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   div_fl_seq_if.slave  bus
);
   state_e                state_q, state_d;
   logic                  sa_q, sgn_q, az_q, bz_q, div0_q;
   logic signed [NBE-1:0] ediff_q, e_hi, e_lo, e_n;
   logic [NBW-1:0]        out_q, res_n;
   logic [NBMANT:0]       q;
   logic [NBMANT-1:0]     mant_n;
   logic                  accept, last;

   assign accept = bus.start && (state_q == IDLE || state_q == FIN);

   div_fl_seq_mant_core #(.NB(NBMANT)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .ma_i   (f_mant(bus.a)),
      .mb_i   (f_mant(bus.b)),
      .q_o    (q),
      .last_o (last)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: a new request wins in IDLE and in the done cycle
   always_comb begin
      state_d = accept             ? CALC :
                state_q == CALC    ? (last ? NORM : CALC) :
                state_q == NORM    ? FIN :
                state_q == FIN     ? IDLE : state_q;
   end

   // Capture sign, exponent difference and zero flags when a request is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q    <= 1'b0;
         sgn_q   <= 1'b0;
         az_q    <= 1'b0;
         bz_q    <= 1'b0;
         ediff_q <= '0;
      end else if (accept) begin
         sa_q    <= f_sign(bus.a);
         sgn_q   <= f_sign(bus.a) ^ f_sign(bus.b);
         az_q    <= f_mant(bus.a) == '0;
         bz_q    <= f_mant(bus.b) == '0;
         ediff_q <= f_expo(bus.a) - f_expo(bus.b);
      end
   end

   // Normalize the quotient and resolve divide-by-zero, zero dividend, overflow and underflow
   always_comb begin
      e_hi   = ediff_q - NBE'(NBMANT - 1);
      e_lo   = ediff_q - NBE'(NBMANT);
      e_n    = q[NBMANT] ? e_hi : e_lo;
      mant_n = q[NBMANT] ? q[NBMANT:1] : q[NBMANT-1:0];
      res_n  = bz_q          ? f_pack(sa_q & ~az_q, EXPO_TOP, MANT_ONES) :
               az_q          ? ZERO :
               e_n > EXP_MAX ? f_pack(sgn_q, EXPO_TOP, MANT_ONES) :
               e_n < EXP_MIN ? ZERO :
                               f_pack(sgn_q, e_n[NBEXPO-1:0], mant_n);
   end

   // Result registers update on the way into FIN so they are valid with done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= ZERO;
         div0_q <= 1'b0;
      end else if (state_q == NORM) begin
         out_q  <= res_n;
         div0_q <= bz_q;
      end
   end

   assign bus.busy = state_q == CALC || state_q == NORM;
   assign bus.done = state_q == FIN;
   assign bus.out  = out_q;
   assign bus.div0 = div0_q;
endmodule
